freq_counter_avg_param: RTL and testbench

- Parametrised successor to the single-channel square-wave frequency counter.
- Synchronises and debounces one external square wave, then counts rising edges over a fixed gate window of mclk cycles, scaling the count to Hz.
- Keeps a true moving average over the last 2^AVG_LOG2 windows in a ring buffer.
- Feeds the display/binary-to-BCD path with a raw or averaged reading plus valid and overflow flags.

---
 rtl/freq_counter_avg_param.sv | 214 +++++++++++++++++++++
 tb/tb_freq_counter_avg_param.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/freq_counter_avg_param.sv
// Square-wave frequency counter: synchronise and debounce one input, count rising
// edges per gate window, scale to Hz and keep a moving average over 2^AVG_LOG2 windows.
module freq_counter_avg_param #(
    parameter int unsigned GATE_CYCLES = 3125000,
    parameter int unsigned SCALE_SHIFT = 4,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned AVG_LOG2    = 3,
    parameter int unsigned DEB_LEN     = 4
) (
    input  logic             mclk,
    input  logic             rst_n,
    input  logic             signal,
    input  logic             avg_en,
    input  logic             clear,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             avg_ready,
    output logic             ovf
);

    localparam int unsigned GATE_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned BUF_N  = 1 << PTR_W;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam int unsigned SUM_W  = CNT_W + AVG_LOG2;
    localparam int unsigned SCL_W  = CNT_W + SCALE_SHIFT;

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(DEPTH - 1);

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Input path
    logic [1:0]         r_sync;
    logic [DEB_LEN-1:0] r_hist;
    logic [DEB_LEN-1:0] w_hist_next;
    logic               r_sig_f;
    logic               r_sig_f_d;
    logic               w_rise;

    // Window counting
    logic [GATE_W-1:0]  r_gate_cnt;
    logic [CNT_W-1:0]   r_edge_cnt;
    logic               r_win_ovf;
    logic               w_gate_end;
    logic               w_close;
    logic               w_cnt_sat;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   w_cnt_total;
    logic               w_ovf_cnt;
    logic [SCL_W-1:0]   w_scaled;
    logic               w_scl_ovf;
    logic [CNT_W-1:0]   w_sample;

    // Averaging
    logic [CNT_W-1:0]   r_buf [BUF_N];
    logic [SUM_W-1:0]   r_sum;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [FILL_W-1:0]  r_fill_cnt;
    logic [SUM_W-1:0]   w_sum_next;
    logic [CNT_W-1:0]   w_avg;
    logic [PTR_W-1:0]   w_ptr_next;

    // Control and outputs
    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [CNT_W-1:0]   r_freq;
    logic               r_valid;
    logic               r_ready;
    logic               r_ovf;

    // Two-flop synchroniser, then a level is accepted only after DEB_LEN agreeing samples
    assign w_hist_next = DEB_LEN'({r_hist, r_sync[1]});

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_hist    <= '0;
            r_sig_f   <= 1'b0;
            r_sig_f_d <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], signal};
            r_hist    <= w_hist_next;
            if (&r_hist) begin
                r_sig_f <= 1'b1;
            end else if (~|r_hist) begin
                r_sig_f <= 1'b0;
            end
            r_sig_f_d <= r_sig_f;
        end
    end

    assign w_rise = r_sig_f & ~r_sig_f_d;

    // The terminal-cycle edge folds into the closing sample, never into the next window
    assign w_gate_end  = (r_gate_cnt == GATE_LAST);
    assign w_close     = w_gate_end & ~clear;
    assign w_cnt_sat   = (r_edge_cnt == CNT_MAX);
    assign w_cnt_inc   = w_cnt_sat ? r_edge_cnt : r_edge_cnt + CNT_W'(1);
    assign w_cnt_total = w_rise ? w_cnt_inc : r_edge_cnt;
    assign w_ovf_cnt   = r_win_ovf | (w_rise & w_cnt_sat);
    assign w_scaled    = SCL_W'(w_cnt_total) << SCALE_SHIFT;
    assign w_scl_ovf   = (w_scaled > SCL_W'(CNT_MAX));
    assign w_sample    = w_scl_ovf ? CNT_MAX : w_scaled[CNT_W-1:0];

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end else if (clear || w_gate_end) begin
            r_gate_cnt <= '0;
            r_edge_cnt <= '0;
            r_win_ovf  <= 1'b0;
        end else begin
            r_gate_cnt <= r_gate_cnt + GATE_W'(1);
            if (w_rise) begin
                r_edge_cnt <= w_cnt_inc;
                r_win_ovf  <= w_ovf_cnt;
            end
        end
    end

    // Running sum replaces the oldest sample, so it is bounded by DEPTH * CNT_MAX
    assign w_sum_next = r_sum - SUM_W'(r_buf[r_wr_ptr]) + SUM_W'(w_sample);
    assign w_avg      = CNT_W'(w_sum_next >> AVG_LOG2);
    assign w_ptr_next = (AVG_LOG2 == 0) ? '0 : r_wr_ptr + PTR_W'(1);

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BUF_N; i++) begin
                r_buf[i] <= '0;
            end
            r_sum      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < BUF_N; i++) begin
                r_buf[i] <= '0;
            end
            r_sum      <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
        end else if (w_close) begin
            r_buf[r_wr_ptr] <= w_sample;
            r_sum           <= w_sum_next;
            r_wr_ptr        <= w_ptr_next;
            if (r_state == ST_FILL) begin
                r_fill_cnt <= r_fill_cnt + FILL_W'(1);
            end
        end
    end

    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Clear overrides a window close landing in the same cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FILL: begin
                if (w_close && (r_fill_cnt == FILL_LAST)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_FILL;
            end
        endcase
        if (clear) begin
            w_state_next = ST_FILL;
        end
    end

    // freq and ovf only move on a window close; clear leaves them holding
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_freq  <= '0;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= w_close;
            r_ready <= (w_state_next == ST_RUN);
            if (w_close) begin
                if (!avg_en) begin
                    r_freq <= w_sample;
                end else if (w_state_next == ST_RUN) begin
                    r_freq <= w_avg;
                end else begin
                    r_freq <= '0;
                end
                r_ovf <= w_ovf_cnt | w_scl_ovf;
            end
        end
    end

    assign freq       = r_freq;
    assign freq_valid = r_valid;
    assign avg_ready  = r_ready;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_freq_counter_avg_param.sv
// Bench for freq_counter_avg_param: two widths driven from one stimulus stream,
// checked every cycle against a window-level reference model.
module tb_freq_counter_avg_param;

    localparam int unsigned GATE = 100;
    localparam int unsigned SS   = 0;
    localparam int unsigned AVG  = 2;
    localparam int unsigned DEB  = 2;
    localparam int unsigned WA   = 8;
    localparam int unsigned WB   = 4;
    localparam int unsigned D    = 1 << AVG;
    localparam int MAX_A = (1 << WA) - 1;
    localparam int MAX_B = (1 << WB) - 1;

    logic          mclk = 1'b0;
    logic          rst_n;
    logic          signal;
    logic          avg_en;
    logic          clear;
    logic [WA-1:0] freq_a;
    logic          valid_a, ready_a, ovf_a;
    logic [WB-1:0] freq_b;
    logic          valid_b, ready_b, ovf_b;

    always #5 mclk = ~mclk;

    freq_counter_avg_param #(
        .GATE_CYCLES(GATE), .SCALE_SHIFT(SS), .CNT_W(WA), .AVG_LOG2(AVG), .DEB_LEN(DEB)
    ) u_dut_a (
        .mclk(mclk), .rst_n(rst_n), .signal(signal), .avg_en(avg_en), .clear(clear),
        .freq(freq_a), .freq_valid(valid_a), .avg_ready(ready_a), .ovf(ovf_a)
    );

    freq_counter_avg_param #(
        .GATE_CYCLES(GATE), .SCALE_SHIFT(SS), .CNT_W(WB), .AVG_LOG2(AVG), .DEB_LEN(DEB)
    ) u_dut_b (
        .mclk(mclk), .rst_n(rst_n), .signal(signal), .avg_en(avg_en), .clear(clear),
        .freq(freq_b), .freq_valid(valid_b), .avg_ready(ready_b), .ovf(ovf_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: raw sample history, filtered level, per-window totals, sample queues
    logic [7:0] s_hist;
    logic [2:0] f_hist;
    int         m_cnt, m_gate, m_n;
    int         q_a[$];
    int         q_b[$];
    int         exp_freq_a, exp_freq_b;
    logic       exp_ovf_a, exp_ovf_b;
    logic       exp_valid, exp_ready;
    int         since_rel, first_at;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int avg_of(input int q[$]);
        int s = 0;
        foreach (q[i]) s += q[i];
        return s / int'(D);
    endfunction

    task automatic model_reset();
        s_hist = '0; f_hist = '0;
        m_cnt = 0; m_gate = 0; m_n = 0;
        q_a.delete(); q_b.delete();
        exp_freq_a = 0; exp_freq_b = 0;
        exp_ovf_a = 1'b0; exp_ovf_b = 1'b0;
        exp_valid = 1'b0; exp_ready = 1'b0;
    endtask

    task automatic model_edge(input logic sig, input logic aen, input logic clr);
        logic rise, f_new;
        int   total, scaled, sa, sb;
        rise   = f_hist[0] & ~f_hist[1];
        s_hist = {s_hist[6:0], sig};
        // After two synchroniser stages the level needs both debounce samples to agree
        f_new  = (s_hist[3] == s_hist[4]) ? s_hist[3] : f_hist[0];
        f_hist = {f_hist[1:0], f_new};
        exp_valid = 1'b0;
        if (clr) begin
            m_cnt = 0; m_gate = 0; m_n = 0;
            q_a.delete(); q_b.delete();
            exp_ready = 1'b0;
        end else if (m_gate == int'(GATE) - 1) begin
            total  = m_cnt + int'(rise);
            scaled = total << SS;
            sa = (scaled > MAX_A) ? MAX_A : scaled;
            sb = (scaled > MAX_B) ? MAX_B : scaled;
            q_a.push_back(sa);
            q_b.push_back(sb);
            if (q_a.size() > int'(D)) void'(q_a.pop_front());
            if (q_b.size() > int'(D)) void'(q_b.pop_front());
            m_n++;
            exp_ready  = (m_n >= int'(D));
            exp_freq_a = !aen ? sa : (exp_ready ? avg_of(q_a) : 0);
            exp_freq_b = !aen ? sb : (exp_ready ? avg_of(q_b) : 0);
            exp_ovf_a  = (scaled > MAX_A);
            exp_ovf_b  = (scaled > MAX_B);
            exp_valid  = 1'b1;
            m_cnt = 0; m_gate = 0;
        end else begin
            m_cnt += int'(rise);
            m_gate++;
        end
    endtask

    task automatic check_all();
        chk("valid_a", 32'(valid_a), 32'(exp_valid));
        chk("valid_b", 32'(valid_b), 32'(exp_valid));
        chk("freq_a",  32'(freq_a),  32'(exp_freq_a));
        chk("freq_b",  32'(freq_b),  32'(exp_freq_b));
        chk("ovf_a",   32'(ovf_a),   32'(exp_ovf_a));
        chk("ovf_b",   32'(ovf_b),   32'(exp_ovf_b));
        chk("ready_a", 32'(ready_a), 32'(exp_ready));
        chk("ready_b", 32'(ready_b), 32'(exp_ready));
    endtask

    task automatic cyc(input logic sig, input logic aen, input logic clr);
        signal = sig; avg_en = aen; clear = clr;
        @(posedge mclk);
        #1;
        model_edge(sig, aen, clr);
        check_all();
        since_rel++;
        // Cycle numbering: the first clock cycle after release is cycle 1
        if (valid_a && first_at < 0) first_at = since_rel + 1;
    endtask

    task automatic run_wave(input int half, input int n, input logic aen);
        for (int i = 0; i < n; i++) cyc(((i / half) % 2) == 1, aen, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_freq_a"},  32'(freq_a),  32'd0);
        chk({tag, "_valid_a"}, 32'(valid_a), 32'd0);
        chk({tag, "_ready_a"}, 32'(ready_a), 32'd0);
        chk({tag, "_ovf_a"},   32'(ovf_a),   32'd0);
        chk({tag, "_freq_b"},  32'(freq_b),  32'd0);
        chk({tag, "_ovf_b"},   32'(ovf_b),   32'd0);
    endtask

    task automatic release_reset();
        rst_n = 1'b1;
        model_reset();
        since_rel = 0;
        first_at  = -1;
    endtask

    initial begin
        logic lvl;
        int   hold;
        logic aen;
        int   mode, h;

        rst_n = 1'b0; signal = 1'b0; avg_en = 1'b0; clear = 1'b0;
        repeat (3) @(posedge mclk);
        #1;
        check_zero_outputs("por");
        release_reset();

        // Period-10 wave, raw readings; first strobe is in cycle 101
        run_wave(5, 3 * GATE, 1'b0);
        chk("first_strobe_cycle", 32'(first_at), 32'd101);

        // Rising rates with averaging on, then a steady rate
        clear = 1'b1; cyc(1'b0, 1'b1, 1'b1);
        run_wave(12, GATE, 1'b1);
        run_wave(6,  GATE, 1'b1);
        run_wave(4,  GATE, 1'b1);
        run_wave(3,  GATE, 1'b1);
        run_wave(3,  3 * GATE, 1'b1);
        chk("avg_ready_after_fill", 32'(ready_a), 32'd1);

        // Single-cycle glitches are rejected, two-cycle pulses counted
        for (int i = 0; i < 2 * int'(GATE); i++) cyc((i % 7) == 3, 1'b0, 1'b0);
        for (int i = 0; i < 2 * int'(GATE); i++) cyc((i % 7) == 3 || (i % 7) == 4, 1'b0, 1'b0);

        // Fastest accepted rate saturates the narrow instance; then a normal window
        run_wave(2, 2 * GATE, 1'b0);
        run_wave(5, 2 * GATE, 1'b0);

        // Clear mid-run: readiness drops, gate restarts, average refills
        run_wave(5, 4 * GATE + 37, 1'b1);
        cyc(1'b0, 1'b1, 1'b1);
        chk("ready_after_clear", 32'(ready_a), 32'd0);
        since_rel = 0; first_at = -1;
        run_wave(5, 5 * GATE, 1'b1);
        chk("strobe_after_clear", 32'(first_at), 32'd101);

        // Asynchronous reset in the middle of a window
        run_wave(4, 53, 1'b0);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("mid_rst");
        repeat (3) @(posedge mclk);
        #1;
        check_zero_outputs("mid_rst_hold");
        release_reset();
        run_wave(5, 5 * GATE, 1'b1);
        chk("strobe_after_reset", 32'(first_at), 32'd101);

        // Randomised windows: mixed patterns, avg_en changes and occasional clears
        lvl = 1'b0; hold = 0;
        for (int w = 0; w < 14; w++) begin
            aen  = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 2));
            h    = int'($urandom_range(2, 9));
            for (int i = 0; i < int'(GATE); i++) begin
                case (mode)
                    0: lvl = ((i / h) % 2) == 1;
                    1: begin
                        if (hold == 0) begin
                            lvl  = 1'($urandom_range(0, 1));
                            hold = int'($urandom_range(1, 6));
                        end
                        hold--;
                    end
                    default: lvl = 1'($urandom_range(0, 1));
                endcase
                cyc(lvl, aen, $urandom_range(0, 299) == 0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
